// File: rtl/uart_transceiver.sv
// 8N1 UART transceiver: independent TX serializer and RX deserializer
// sharing one clock, with a 2-flop synchronizer on the serial input.
module uart_transceiver #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF =
    (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------- TX ----------------
  state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_line_q, tx_line_d;
  logic            tx_busy_q, tx_busy_d;

  // TX next state: line level is registered so it changes on state edges
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    unique case (tx_state_q)
      S_IDLE: begin
        tx_line_d = 1'b1;
        tx_busy_d = 1'b0;
        tx_cnt_d  = '0;
        if (tx_start) begin
          tx_shift_d = tx_data;
          tx_line_d  = 1'b0;
          tx_busy_d  = 1'b1;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = S_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_line_d  = 1'b1;
          tx_busy_d  = 1'b0;
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
      end
    endcase
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  assign tx      = tx_line_q;
  assign tx_busy = tx_busy_q;

  // ---------------- RX ----------------
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  state_t          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;

  // Synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX next state: half-bit offset then mid-bit sampling
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    unique case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_valid_d = 1'b0;
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          if (rx_sync_q) rx_state_d = S_IDLE;
          else           rx_state_d = S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        rx_state_d = S_IDLE;
      end
    endcase
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at default baud settings.
// Loopback and externally driven RX frames.
module tb_uart_transceiver;

  localparam int CPB = 434;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_w;
  logic       tx_busy;
  logic       rx_w;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       loop_en;
  logic       rx_drv;

  int total;
  int bad;

  assign rx_w = loop_en ? tx_w : rx_drv;

  uart_transceiver dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx       (tx_w),
    .tx_busy  (tx_busy),
    .rx       (rx_w),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // called at a negedge; start is seen at the following posedge
  task automatic start_tx(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    while (tx_busy === 1'b1 && n < 6000) begin
      @(negedge clk);
      if (tx_busy === 1'b1) n++;
    end
    chk("busy_fall", 32'(tx_busy), 32'd0);
  endtask

  task automatic send_rx(input logic [7:0] b,
                         input logic stop_b);
    logic [9:0] fr;
    fr = {stop_b, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [9:0] f55;
    logic [7:0] seq [4];
    int n, n1, tx_bad, busy_n, seen;

    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    loop_en  = 1'b1;
    rx_drv   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_w), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_rxv", 32'(rx_valid), 32'd0);
    chk("rst_rxd", 32'(rx_data), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: back-to-back loopback
    seq[0] = 8'h55;
    seq[1] = 8'hA5;
    seq[2] = 8'h0F;
    seq[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      start_tx(seq[i]);
      wait_fall(n);
      chk("lb_valid", 32'(rx_valid), 32'd1);
      chk("lb_data", 32'(rx_data), 32'(seq[i]));
    end
    repeat (20) @(negedge clk);

    // 2: exact waveform of 0x55
    f55 = {1'b1, 8'h55, 1'b0};
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(posedge clk);
    tx_bad = 0;
    busy_n = 0;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      if (tx_w !== f55[k / CPB]) tx_bad++;
      if (tx_busy === 1'b1) busy_n++;
      if (k % CPB == CPB / 2)
        chk("wave_mid", 32'(tx_w), 32'(f55[k / CPB]));
    end
    chk("wave_bad", 32'(tx_bad), 32'd0);
    chk("wave_busy_len", 32'(busy_n), 32'd4340);
    @(negedge clk);
    chk("wave_end_busy", 32'(tx_busy), 32'd0);
    chk("wave_end_tx", 32'(tx_w), 32'd1);
    chk("wave_rx", 32'(rx_data), 32'h55);
    repeat (20) @(negedge clk);

    // 3: start while busy is ignored
    tx_data  = 8'h34;
    tx_start = 1'b1;
    @(posedge clk);
    n1 = 0;
    for (int k = 0; k < 1001; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      if (tx_busy === 1'b1) n1++;
      if (k == 999) begin
        tx_data  = 8'h12;
        tx_start = 1'b1;
      end
    end
    wait_fall(n);
    chk("busy_len34", 32'(n1 + n), 32'd4340);
    chk("rx34_valid", 32'(rx_valid), 32'd1);
    chk("rx34_data", 32'(rx_data), 32'h34);
    seen = 0;
    for (int k = 0; k < 2 * CPB; k++) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx_w !== 1'b1) seen++;
    end
    chk("no_queue", 32'(seen), 32'd0);

    // 4: glitch then a good frame
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (10) @(negedge clk);
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    rx_drv = 1'b1;
    repeat (1000) @(negedge clk);
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    chk("glitch_data", 32'(rx_data), 32'h34);
    send_rx(8'hC3, 1'b1);
    repeat (10) @(negedge clk);
    chk("c3_valid", 32'(rx_valid), 32'd1);
    chk("c3_data", 32'(rx_data), 32'hC3);

    // 5: framing error
    send_rx(8'h3C, 1'b0);
    repeat (50) @(negedge clk);
    chk("ferr_valid", 32'(rx_valid), 32'd0);
    chk("ferr_data", 32'(rx_data), 32'hC3);

    // 6: reset mid-frame, then recover
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    start_tx(8'h5A);
    repeat (2000) @(negedge clk);
    chk("mid_busy", 32'(tx_busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mrst_tx", 32'(tx_w), 32'd1);
    chk("mrst_busy", 32'(tx_busy), 32'd0);
    chk("mrst_rxv", 32'(rx_valid), 32'd0);
    chk("mrst_rxd", 32'(rx_data), 32'h0);
    repeat (10) @(negedge clk);
    start_tx(8'hA5);
    wait_fall(n);
    chk("post_valid", 32'(rx_valid), 32'd1);
    chk("post_data", 32'(rx_data), 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
